// File: rtl/adpcm_player_if.sv
// Sound-ROM read port between the ADPCM playback sequencer and the ROM.
interface adpcm_player_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              rom_rd;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;
    logic              rom_valid;

    // Sequencer side: issues reads, receives data.
    modport master (
        output rom_rd,
        output rom_addr,
        input  rom_data,
        input  rom_valid
    );

    // ROM side: accepts reads, returns data.
    modport slave (
        input  rom_rd,
        input  rom_addr,
        output rom_data,
        output rom_valid
    );
endinterface

// File: rtl/adpcm_player.sv
// Playback sequencer for a 4-bit Dialogic ADPCM decoder: fetches packed bytes
// from sound ROM and feeds one nibble per sample tick, high nibble first.
module adpcm_player #(
    parameter int unsigned CLK_DIV = 6250,
    parameter int unsigned ADDR_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic              busy,
    output logic              done,
    output logic              underrun,
    output logic              dec_reset,
    output logic              dec_ce,
    output logic [3:0]        dec_nibble,
    adpcm_player_if.master    rom
);
    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        StIdle, StDrst, StFetch, StWait, StHi, StLo, StDone
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [7:0]        byte_q, byte_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pending_q, pending_d;
    logic              underrun_q, underrun_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              rom_rd_q, rom_rd_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              dec_reset_q, dec_reset_d;
    logic              dec_ce_q, dec_ce_d;
    logic [3:0]        dec_nibble_q, dec_nibble_d;

    logic running, tick, in_play, consume;

    // Tick generation and consumption qualifiers.
    always_comb begin
        running = (state_q != StIdle) && (state_q != StDrst);
        tick    = running && (cnt_q == CNT_MAX);
        in_play = (state_q == StHi) || (state_q == StLo);
        consume = in_play && (tick || pending_q) && !stop;
    end

    // Next-state logic for the sequencer, tick bookkeeping and registered outputs.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        end_d      = end_q;
        byte_d     = byte_q;
        cnt_d      = '0;
        pending_d  = pending_q;
        underrun_d = underrun_q;

        if (running) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end

        // A tick that arrives while a previous one is still owed is lost.
        if (!stop) begin
            if (in_play) begin
                if (tick || pending_q) begin
                    pending_d = 1'b0;
                end
            end else if (tick) begin
                if (pending_q) begin
                    underrun_d = 1'b1;
                end else begin
                    pending_d = 1'b1;
                end
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    addr_d     = start_addr;
                    end_d      = end_addr;
                    underrun_d = 1'b0;
                    state_d    = StDrst;
                end
            end
            StDrst: begin
                pending_d = 1'b0;
                state_d   = StFetch;
            end
            StFetch: state_d = StWait;
            StWait: begin
                if (rom.rom_valid) begin
                    byte_d  = rom.rom_data;
                    state_d = StHi;
                end
            end
            StHi: begin
                if (consume) begin
                    state_d = StLo;
                end
            end
            StLo: begin
                if (consume) begin
                    if (addr_q == end_q) begin
                        state_d = StDone;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = StFetch;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (stop && (state_q != StIdle)) begin
            state_d = StIdle;
        end

        // Outputs are registered, so they are derived from the upcoming state.
        dec_reset_d  = (state_d == StDrst);
        rom_rd_d     = (state_d == StFetch);
        rom_addr_d   = rom_rd_d ? addr_d : rom_addr_q;
        dec_ce_d     = consume;
        dec_nibble_d = dec_nibble_q;
        if (consume) begin
            dec_nibble_d = (state_q == StHi) ? byte_q[7:4] : byte_q[3:0];
        end
        done_d = (state_q == StDone) && !stop;
        // busy stays up through the done pulse and falls the cycle after.
        busy_d = (state_d != StIdle) || done_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            addr_q       <= '0;
            end_q        <= '0;
            byte_q       <= '0;
            cnt_q        <= '0;
            pending_q    <= 1'b0;
            underrun_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            rom_rd_q     <= 1'b0;
            rom_addr_q   <= '0;
            dec_reset_q  <= 1'b0;
            dec_ce_q     <= 1'b0;
            dec_nibble_q <= '0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            end_q        <= end_d;
            byte_q       <= byte_d;
            cnt_q        <= cnt_d;
            pending_q    <= pending_d;
            underrun_q   <= underrun_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            rom_rd_q     <= rom_rd_d;
            rom_addr_q   <= rom_addr_d;
            dec_reset_q  <= dec_reset_d;
            dec_ce_q     <= dec_ce_d;
            dec_nibble_q <= dec_nibble_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign underrun     = underrun_q;
    assign dec_reset    = dec_reset_q;
    assign dec_ce       = dec_ce_q;
    assign dec_nibble   = dec_nibble_q;
    assign rom.rom_rd   = rom_rd_q;
    assign rom.rom_addr = rom_addr_q;
endmodule
